uart_tx_arbiter: RTL

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_tx_arbiter_if.sv | 35 +++
 rtl/rr_arb2.sv | 17 +
 rtl/uart_tx_arbiter.sv | 139 +++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the two-requester UART transmit arbiter:
// FSM encoding, counter type and default limits.
package uart_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SEND,
      ST_WRITE,
      ST_WAIT
   } arb_state_t;

   localparam int unsigned CNT_W                = 8;
   localparam int unsigned MAX_BURST_DEFAULT    = 16;
   localparam int unsigned HOLD_TIMEOUT_DEFAULT = 255;

   typedef logic [CNT_W-1:0] cnt_t;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester and transmitter signals of the UART transmit arbiter.
// slave is the arbiter's view; master is the surrounding system's view.
interface uart_tx_arbiter_if;

   logic       req0_valid;
   logic [7:0] req0_data;
   logic       req0_last;
   logic       req0_ready;
   logic       req1_valid;
   logic [7:0] req1_data;
   logic       req1_last;
   logic       req1_ready;
   logic [7:0] tx_data;
   logic       tx_wr;
   logic       tx_tbr_valid;
   logic [1:0] grant;
   logic       busy;

   modport slave (
      input  req0_valid, req0_data, req0_last,
      input  req1_valid, req1_data, req1_last,
      input  tx_tbr_valid,
      output req0_ready, req1_ready,
      output tx_data, tx_wr, grant, busy
   );

   modport master (
      output req0_valid, req0_data, req0_last,
      output req1_valid, req1_data, req1_last,
      output tx_tbr_valid,
      input  req0_ready, req1_ready,
      input  tx_data, tx_wr, grant, busy
   );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin pick: a lone requester wins outright, a tie goes
// to the requester that was not served last.
module rr_arb2 (
   input  logic [1:0] req,
   input  logic       last_served,
   output logic [1:0] pick
);

   // NOTE: every output of an always_comb gets a default first so no path can infer a latch.
   always_comb begin
      pick = req;
      if (req == 2'b11) begin
         pick = last_served ? 2'b01 : 2'b10;
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Arbitrates two byte streams onto one UART transmitter buffer, with
// per-grant burst cap, hold timeout and a guard cycle after each write.
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int unsigned MAX_BURST    = MAX_BURST_DEFAULT,
   parameter int unsigned HOLD_TIMEOUT = HOLD_TIMEOUT_DEFAULT
) (
   input logic               clk,
   input logic               reset,
   uart_tx_arbiter_if.slave  bus
);

   localparam cnt_t BURST_LIMIT = cnt_t'(MAX_BURST);
   localparam cnt_t HOLD_LIMIT  = cnt_t'(HOLD_TIMEOUT);

   arb_state_t state_q, state_d;
   logic [1:0] grant_q, grant_d;
   logic       last_served_q, last_served_d;
   cnt_t       burst_q, burst_d;
   cnt_t       idle_q, idle_d;
   logic [7:0] data_q, data_d;
   logic       last_q, last_d;
   logic       guard_q, guard_d;

   logic [1:0] pick;
   logic       owner_valid;
   logic [7:0] owner_data;
   logic       owner_last;

   rr_arb2 u_rr_arb2 (
      .req         ({bus.req1_valid, bus.req0_valid}),
      .last_served (last_served_q),
      .pick        (pick)
   );

   // Owner index is grant bit 1; the mux is only consumed while a grant is held.
   always_comb begin
      owner_valid = grant_q[1] ? bus.req1_valid : bus.req0_valid;
      owner_data  = grant_q[1] ? bus.req1_data  : bus.req0_data;
      owner_last  = grant_q[1] ? bus.req1_last  : bus.req0_last;
   end

   always_comb begin
      state_d        = state_q;
      grant_d        = grant_q;
      last_served_d  = last_served_q;
      burst_d        = burst_q;
      idle_d         = idle_q;
      data_d         = data_q;
      last_d         = last_q;
      guard_d        = guard_q;
      bus.req0_ready = 1'b0;
      bus.req1_ready = 1'b0;
      bus.tx_wr      = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (pick != 2'b00) begin
               grant_d = pick;
               burst_d = '0;
               idle_d  = '0;
               state_d = ST_SEND;
            end
         end

         ST_SEND: begin
            bus.req0_ready = grant_q[0] & bus.req0_valid & ~bus.tx_tbr_valid;
            bus.req1_ready = grant_q[1] & bus.req1_valid & ~bus.tx_tbr_valid;
            if (owner_valid) begin
               idle_d = '0;
               if (!bus.tx_tbr_valid) begin
                  data_d  = owner_data;
                  last_d  = owner_last;
                  burst_d = burst_q + 8'd1;
                  state_d = ST_WRITE;
               end
            end else if (idle_q + 8'd1 == HOLD_LIMIT) begin
               last_served_d = grant_q[1];
               grant_d       = 2'b00;
               state_d       = ST_IDLE;
            end else begin
               idle_d = idle_q + 8'd1;
            end
         end

         ST_WRITE: begin
            bus.tx_wr = 1'b1;
            guard_d   = 1'b1;
            state_d   = ST_WAIT;
         end

         ST_WAIT: begin
            // The transmitter's occupied flag lags the write by a cycle, so the first WAIT cycle ignores it.
            if (guard_q) begin
               guard_d = 1'b0;
            end else if (!bus.tx_tbr_valid) begin
               if (last_q || burst_q == BURST_LIMIT) begin
                  last_served_d = grant_q[1];
                  grant_d       = 2'b00;
                  state_d       = ST_IDLE;
               end else begin
                  state_d = ST_SEND;
               end
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         grant_q       <= 2'b00;
         last_served_q <= 1'b1;
         burst_q       <= '0;
         idle_q        <= '0;
         data_q        <= 8'h00;
         last_q        <= 1'b0;
         guard_q       <= 1'b0;
      end else begin
         state_q       <= state_d;
         grant_q       <= grant_d;
         last_served_q <= last_served_d;
         burst_q       <= burst_d;
         idle_q        <= idle_d;
         data_q        <= data_d;
         last_q        <= last_d;
         guard_q       <= guard_d;
      end
   end

   assign bus.grant   = grant_q;
   assign bus.busy    = (state_q != ST_IDLE);
   assign bus.tx_data = data_q;

endmodule
